// File: rtl/arb_defs_pkg.sv
// Shared definitions for the 3-way round-robin arbiter: state encodings,
// the "no owner" id, and index helpers for a 3-entry ring.
package arb_defs;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   localparam logic [1:0] NO_OWNER = 2'b11;

   // Next index on the 0..2 ring.
   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i >= 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   function automatic logic [2:0] onehot3(input logic [1:0] i);
      return 3'b001 << i;
   endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational rotating-priority scan: first set request starting at ptr.
module rr_pick3
   import arb_defs::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] win
);

   logic [1:0] p0, p1, p2;

   always_comb begin
      // ptr is never 3 in practice; clamp so the scan stays inside the ring.
      p0    = (ptr > 2'd2) ? 2'd0 : ptr;
      p1    = next_idx(p0);
      p2    = next_idx(p1);
      valid = |req;
      win   = NO_OWNER;
      if (req[p0])      win = p0;
      else if (req[p1]) win = p1;
      else if (req[p2]) win = p2;
   end

endmodule

// File: rtl/rr_arbiter3.sv
// Round-robin arbiter for three requesters sharing one datapath. Registered
// one-hot grant held while the owner requests, with an optional hold limit.
module rr_arbiter3
   import arb_defs::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int HOLD_W   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   output logic [2:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       forced
);

   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   state_e            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        owner_q, owner_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              forced_q, forced_d;

   logic       pick_valid;
   logic [1:0] pick_win;
   logic       owner_req, others_req, limit_hit;

   rr_pick3 u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .win   (pick_win)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      gnt_d      = gnt_q;
      hold_d     = hold_q;
      forced_d   = 1'b0;
      owner_req  = |(req & gnt_q);
      others_req = |(req & ~gnt_q);
      limit_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_GRANT;
               owner_d = pick_win;
               gnt_d   = onehot3(pick_win);
               hold_d  = HOLD_W'(1);
            end
         end
         ST_GRANT: begin
            if (!owner_req || (limit_hit && others_req)) begin
               state_d  = ST_IDLE;
               owner_d  = NO_OWNER;
               gnt_d    = 3'b000;
               hold_d   = '0;
               ptr_d    = next_idx(owner_q);
               // A voluntary drop wins over the limit on the same edge.
               forced_d = owner_req;
            end else if ((MAX_HOLD != 0) && (hold_q < HOLD_MAX)) begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 2'd0;
         owner_q  <= NO_OWNER;
         gnt_q    <= 3'b000;
         hold_q   <= '0;
         forced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         gnt_q    <= gnt_d;
         hold_q   <= hold_d;
         forced_q <= forced_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = owner_q;
   assign busy   = (state_q == ST_GRANT);
   assign forced = forced_q;

endmodule

// File: tb/tb_rr_arbiter3.sv
// Scenario bench for rr_arbiter3: a MAX_HOLD=4 instance and a MAX_HOLD=0
// instance share stimulus; expected outputs are queued per driven cycle.
module tb_rr_arbiter3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] req = 3'b000;
   logic [2:0] gnt, gnt0;
   logic [1:0] gnt_id, gnt_id0;
   logic       busy, busy0, forced, forced0;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       rst;
      logic [2:0] req;
      logic [2:0] gnt;
      logic       frc;
      logic [2:0] g0;
   } row_t;

   typedef struct packed {
      logic [2:0] gnt;
      logic       frc;
      logic [2:0] g0;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   rr_arbiter3 #(.MAX_HOLD(4), .HOLD_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .forced(forced)
   );

   rr_arbiter3 #(.MAX_HOLD(0), .HOLD_W(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req),
      .gnt(gnt0), .gnt_id(gnt_id0), .busy(busy0), .forced(forced0)
   );

   function automatic logic [1:0] id_of(input logic [2:0] g);
      case (g)
         3'b001:  return 2'd0;
         3'b010:  return 2'd1;
         3'b100:  return 2'd2;
         default: return 2'b11;
      endcase
   endfunction

   task automatic drive(input row_t r);
      exp_t e;
      @(negedge clk);
      rst_n = r.rst;
      req   = r.req;
      e.gnt = r.gnt;
      e.frc = r.frc;
      e.g0  = r.g0;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      row_t t[4] = '{
         {1'b0, 3'b111, 3'b000, 1'b0, 3'b000},
         {1'b0, 3'b111, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000}};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if (gnt !== e.gnt || gnt_id !== id_of(e.gnt) || busy !== (e.gnt != 3'b000) ||
             forced !== e.frc || gnt0 !== e.g0 || gnt_id0 !== id_of(e.g0) || forced0 !== 1'b0) begin
            bad++;
            $display("FAIL reset row%0d: gnt=%b id=%b busy=%b forced=%b gnt0=%b | want gnt=%b forced=%b gnt0=%b",
                     i, gnt, gnt_id, busy, forced, gnt0, e.gnt, e.frc, e.g0);
         end
      end
   endtask

   task automatic test_single();
      row_t t[11] = '{
         {1'b0, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b010, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b010, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b010, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b010, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b010, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b010, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b100, 1'b0, 3'b100}};
      exp_t e;
      for (int i = 0; i < 11; i++) begin
         drive(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if (gnt !== e.gnt || gnt_id !== id_of(e.gnt) || busy !== (e.gnt != 3'b000) ||
             forced !== e.frc || gnt0 !== e.g0 || gnt_id0 !== id_of(e.g0) || forced0 !== 1'b0) begin
            bad++;
            $display("FAIL single row%0d: gnt=%b id=%b busy=%b forced=%b gnt0=%b | want gnt=%b forced=%b gnt0=%b",
                     i, gnt, gnt_id, busy, forced, gnt0, e.gnt, e.frc, e.g0);
         end
      end
   endtask

   task automatic test_rotation();
      row_t t[12] = '{
         {1'b0, 3'b111, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b111, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b110, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b111, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b101, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b100, 1'b0, 3'b100},
         {1'b1, 3'b111, 3'b100, 1'b0, 3'b100},
         {1'b1, 3'b011, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b110, 3'b000, 1'b0, 3'b000}};
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         drive(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if (gnt !== e.gnt || gnt_id !== id_of(e.gnt) || busy !== (e.gnt != 3'b000) ||
             forced !== e.frc || gnt0 !== e.g0 || gnt_id0 !== id_of(e.g0) || forced0 !== 1'b0) begin
            bad++;
            $display("FAIL rotation row%0d: gnt=%b id=%b busy=%b forced=%b gnt0=%b | want gnt=%b forced=%b gnt0=%b",
                     i, gnt, gnt_id, busy, forced, gnt0, e.gnt, e.frc, e.g0);
         end
      end
   endtask

   // Limit-4 instance is revoked; the unlimited instance keeps idx0 throughout.
   task automatic test_hold_limit();
      row_t t[18] = '{
         {1'b0, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b011, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b011, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b011, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b011, 3'b000, 1'b1, 3'b001},
         {1'b1, 3'b011, 3'b010, 1'b0, 3'b001},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b0, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b101, 3'b000, 1'b1, 3'b001},
         {1'b1, 3'b101, 3'b100, 1'b0, 3'b001},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000}};
      exp_t e;
      for (int i = 0; i < 18; i++) begin
         drive(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if (gnt !== e.gnt || gnt_id !== id_of(e.gnt) || busy !== (e.gnt != 3'b000) ||
             forced !== e.frc || gnt0 !== e.g0 || gnt_id0 !== id_of(e.g0) ||
             busy0 !== (e.g0 != 3'b000) || forced0 !== 1'b0) begin
            bad++;
            $display("FAIL hold_limit row%0d: gnt=%b id=%b busy=%b forced=%b gnt0=%b forced0=%b | want gnt=%b forced=%b gnt0=%b",
                     i, gnt, gnt_id, busy, forced, gnt0, forced0, e.gnt, e.frc, e.g0);
         end
      end
   endtask

   task automatic test_simultaneous();
      row_t t[8] = '{
         {1'b0, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b001, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b010, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b010, 1'b0, 3'b010},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000}};
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         drive(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if (gnt !== e.gnt || gnt_id !== id_of(e.gnt) || busy !== (e.gnt != 3'b000) ||
             forced !== e.frc || gnt0 !== e.g0 || gnt_id0 !== id_of(e.g0) || forced0 !== 1'b0) begin
            bad++;
            $display("FAIL simultaneous row%0d: gnt=%b id=%b busy=%b forced=%b gnt0=%b | want gnt=%b forced=%b gnt0=%b",
                     i, gnt, gnt_id, busy, forced, gnt0, e.gnt, e.frc, e.g0);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      row_t t[6] = '{
         {1'b0, 3'b000, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b100, 3'b100, 1'b0, 3'b100},
         {1'b1, 3'b100, 3'b100, 1'b0, 3'b100},
         {1'b0, 3'b100, 3'b000, 1'b0, 3'b000},
         {1'b1, 3'b111, 3'b001, 1'b0, 3'b001},
         {1'b1, 3'b000, 3'b000, 1'b0, 3'b000}};
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         drive(t[i]);
         @(posedge clk); #1;
         e = sb.pop_front();
         total++;
         if (gnt !== e.gnt || gnt_id !== id_of(e.gnt) || busy !== (e.gnt != 3'b000) ||
             forced !== e.frc || gnt0 !== e.g0 || gnt_id0 !== id_of(e.g0) || forced0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid row%0d: gnt=%b id=%b busy=%b forced=%b gnt0=%b | want gnt=%b forced=%b gnt0=%b",
                     i, gnt, gnt_id, busy, forced, gnt0, e.gnt, e.frc, e.g0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_rotation();
      test_hold_limit();
      test_simultaneous();
      test_reset_mid_grant();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
